tap_ir_controller: RTL and testbench
====================================

// Module: tap_ir_controller
// PURPOSE
//  IEEE 1149.1 TAP state machine plus instruction register: the stage directly upstream of the IR decoder.
//  Sequences TMS into the 16 TAP states, captures/shifts/updates the IR, and drives the latched
//  instruction (LATCH_IR) and the DR-scan strobes consumed by the data registers.
//  Single clock domain (TCK); all state changes occur on the rising edge of TCK.
// PARAMETERS
//  IR_WIDTH    4      instruction register length (>=2)
//  IR_CAPTURE  4'h1   value loaded in Capture-IR (bits[1:0] must be 2'b01)
//  IR_RESET    4'h7   LATCH_IR value at reset and in Test-Logic-Reset (IDCODE)
// PORTS
//  TCK           in   1         test clock; all flops rising-edge
//  TRST          in   1         asynchronous reset, active-high
//  TMS           in   1         test mode select, sampled on TCK rise
//  TDI           in   1         serial data in
//  LATCH_IR      out  IR_WIDTH  current instruction, feeds the IR decoder
//  IR_TDO        out  1         IR shift-register bit 0 (serial out during Shift-IR)
//  TDO_ENABLE    out  1         1 in SHIFT_DR or SHIFT_IR
//  TAP_STATE     out  4         current state encoding
//  TAP_RESET     out  1         1 in TEST_LOGIC_RESET
//  SELECT_IR     out  1         1 in any *_IR state (TDO mux select)
//  CAPTURE_DR    out  1         1 in CAPTURE_DR
//  SHIFT_DR      out  1         1 in SHIFT_DR
//  UPDATE_DR     out  1         1 in UPDATE_DR
// BEHAVIOUR
//  Reset (TRST=1, async): state=TEST_LOGIC_RESET, IR shift reg=IR_CAPTURE, LATCH_IR=IR_RESET;
//   all strobes 0 except TAP_RESET=1. Reset mid-scan discards partial IR; no update occurs.
//  State encodings (4'h): TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAU_DR 3,
//   EX2_DR 0, UPD_DR 5, SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAU_IR B, EX2_IR 8, UPD_IR D.
//  Transitions (next on TMS=0 / TMS=1):
//   TLR:RTI/TLR  RTI:RTI/SEL_DR  SEL_DR:CAP_DR/SEL_IR  SEL_IR:CAP_IR/TLR
//   CAP_x:SH_x/EX1_x  SH_x:SH_x/EX1_x  EX1_x:PAU_x/UPD_x  PAU_x:PAU_x/EX2_x
//   EX2_x:SH_x/UPD_x  UPD_x:RTI/SEL_DR   (x = DR or IR)
//  Five consecutive TMS=1 edges reach TLR from any state.
//  IR shift register, per TCK rise by current state:
//   CAP_IR: load IR_CAPTURE.  SH_IR: sr <= {TDI, sr[IR_WIDTH-1:1]} (shifts on the exit edge too,
//   i.e. TMS=1 in SH_IR still shifts).  Other states: hold.
//  LATCH_IR: on TCK rise with current state UPD_IR -> LATCH_IR <= sr (visible the cycle after
//   UPD_IR). On TCK rise with current state TLR -> LATCH_IR <= IR_RESET. Otherwise hold.
//   PAUSE/EXIT states never alter LATCH_IR.
//  All status outputs are decoded from the registered state only (glitch-free, no TMS path).
//  IR_TDO = sr[0] combinationally from the register; valid throughout SH_IR.
// STRUCTURE
//  Shared package/include: TAP state localparams (16 encodings), IR_WIDTH default,
//   IDCODE/BYPASS opcode constants shared with the IR decoder.
//  Sub-module tap_fsm: TCK/TRST/TMS -> TAP_STATE plus one-hot state decodes.
//   Top level instantiates tap_fsm and holds the IR shift/latch registers.
// TESTING
//  1 Assert TRST mid-sim -> TAP_STATE=F, LATCH_IR=7, TAP_RESET=1 immediately (async).
//  2 From SH_DR drive TMS=1 x5 -> TAP_STATE=F; LATCH_IR forced to 7 even after prior load of 2.
//  3 TLR, TMS 0,1,1,0,0 -> SH_IR; shift TDI 0,1,0,0 (last with TMS=1), TMS 1,0 ->
//    LATCH_IR=4'h2 one cycle after UPD_IR; IR_TDO stream observed = 1,0,0,0 (capture value).
//  4 Shift 4'h3 into IR, enter PAU_IR for 10 cycles, EX2_IR, UPD_IR -> LATCH_IR held at old
//    value through pause, becomes 3 only after UPD_IR.
//  5 DR scan RTI->SEL_DR->CAP_DR->SH_DR x3->EX1_DR->UPD_DR -> CAPTURE_DR, SHIFT_DR (3 cycles),
//    UPDATE_DR each high exactly in their states; LATCH_IR unchanged.
//  6 TRST pulse during SH_IR after 2 bits shifted -> no update, LATCH_IR=7, sr=IR_CAPTURE.

Source files
------------

// File: rtl/tap_ir_controller_pkg.sv
// Shared TAP definitions: state encodings, next-state rule, IR sizing and opcodes
// also used by the downstream IR decoder.
package tap_ir_controller_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

  localparam int         IR_WIDTH_DEF   = 4;
  localparam logic [3:0] IR_CAPTURE_DEF = 4'h1;
  localparam logic [3:0] IR_OP_IDCODE   = 4'h7;
  localparam logic [3:0] IR_OP_BYPASS   = 4'hF;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    case (s)
      TLR:     n = tms ? TLR    : RTI;
      RTI:     n = tms ? SEL_DR : RTI;
      SEL_DR:  n = tms ? SEL_IR : CAP_DR;
      CAP_DR:  n = tms ? EX1_DR : SH_DR;
      SH_DR:   n = tms ? EX1_DR : SH_DR;
      EX1_DR:  n = tms ? UPD_DR : PAU_DR;
      PAU_DR:  n = tms ? EX2_DR : PAU_DR;
      EX2_DR:  n = tms ? UPD_DR : SH_DR;
      UPD_DR:  n = tms ? SEL_DR : RTI;
      SEL_IR:  n = tms ? TLR    : CAP_IR;
      CAP_IR:  n = tms ? EX1_IR : SH_IR;
      SH_IR:   n = tms ? EX1_IR : SH_IR;
      EX1_IR:  n = tms ? UPD_IR : PAU_IR;
      PAU_IR:  n = tms ? EX2_IR : PAU_IR;
      EX2_IR:  n = tms ? UPD_IR : SH_IR;
      UPD_IR:  n = tms ? SEL_DR : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

  function automatic logic is_ir_state(input tap_state_t s);
    return (s == SEL_IR) || (s == CAP_IR) || (s == SH_IR) || (s == EX1_IR) ||
           (s == PAU_IR) || (s == EX2_IR) || (s == UPD_IR);
  endfunction

endpackage

// File: rtl/tap_ir_controller_tap_fsm.sv
// TAP state machine: TMS sequenced on TCK rise; decodes are flopped from the next state
// so they match the registered state exactly and carry no combinational TMS path.
module tap_fsm
  import tap_ir_controller_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output logic       tap_reset,
  output logic       select_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       tdo_enable
);

  tap_state_t state_d, state_q;
  logic tap_reset_d, select_ir_d, capture_dr_d, shift_dr_d, update_dr_d, tdo_enable_d;
  logic tap_reset_q, select_ir_q, capture_dr_q, shift_dr_q, update_dr_q, tdo_enable_q;

  always_comb begin
    state_d      = tap_next(state_q, tms);
    tap_reset_d  = (state_d == TLR);
    select_ir_d  = is_ir_state(state_d);
    capture_dr_d = (state_d == CAP_DR);
    shift_dr_d   = (state_d == SH_DR);
    update_dr_d  = (state_d == UPD_DR);
    tdo_enable_d = (state_d == SH_DR) || (state_d == SH_IR);
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state_q      <= TLR;
      tap_reset_q  <= 1'b1;
      select_ir_q  <= 1'b0;
      capture_dr_q <= 1'b0;
      shift_dr_q   <= 1'b0;
      update_dr_q  <= 1'b0;
      tdo_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_reset_q  <= tap_reset_d;
      select_ir_q  <= select_ir_d;
      capture_dr_q <= capture_dr_d;
      shift_dr_q   <= shift_dr_d;
      update_dr_q  <= update_dr_d;
      tdo_enable_q <= tdo_enable_d;
    end
  end

  assign state      = state_q;
  assign tap_reset  = tap_reset_q;
  assign select_ir  = select_ir_q;
  assign capture_dr = capture_dr_q;
  assign shift_dr   = shift_dr_q;
  assign update_dr  = update_dr_q;
  assign tdo_enable = tdo_enable_q;

endmodule

// File: rtl/tap_ir_controller.sv
// TAP controller top: tap_fsm plus IR shift/latch registers; LATCH_IR changes one TCK after
// UPD_IR (or TLR). No backpressure: everything advances on every TCK rise.
module tap_ir_controller
  import tap_ir_controller_pkg::*;
#(
  parameter int                  IR_WIDTH   = IR_WIDTH_DEF,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_DEF),
  parameter logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(IR_OP_IDCODE)
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic [IR_WIDTH-1:0] LATCH_IR,
  output logic                IR_TDO,
  output logic                TDO_ENABLE,
  output logic [3:0]          TAP_STATE,
  output logic                TAP_RESET,
  output logic                SELECT_IR,
  output logic                CAPTURE_DR,
  output logic                SHIFT_DR,
  output logic                UPDATE_DR
);

  tap_state_t          state;
  logic [IR_WIDTH-1:0] sr_d, sr_q;
  logic [IR_WIDTH-1:0] latch_ir_d, latch_ir_q;

  tap_fsm u_tap_fsm (
    .tck        (TCK),
    .trst       (TRST),
    .tms        (TMS),
    .state      (state),
    .tap_reset  (TAP_RESET),
    .select_ir  (SELECT_IR),
    .capture_dr (CAPTURE_DR),
    .shift_dr   (SHIFT_DR),
    .update_dr  (UPDATE_DR),
    .tdo_enable (TDO_ENABLE)
  );

  // The exit edge out of SH_IR (TMS=1) still shifts, so the last bit rides on that edge.
  always_comb begin
    sr_d       = sr_q;
    latch_ir_d = latch_ir_q;
    if (state == CAP_IR) begin
      sr_d = IR_CAPTURE;
    end else if (state == SH_IR) begin
      sr_d = {TDI, sr_q[IR_WIDTH-1:1]};
    end
    if (state == UPD_IR) begin
      latch_ir_d = sr_q;
    end else if (state == TLR) begin
      latch_ir_d = IR_RESET;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      sr_q       <= IR_CAPTURE;
      latch_ir_q <= IR_RESET;
    end else begin
      sr_q       <= sr_d;
      latch_ir_q <= latch_ir_d;
    end
  end

  assign TAP_STATE = state;
  assign LATCH_IR  = latch_ir_q;
  assign IR_TDO    = sr_q[0];

endmodule

// File: tb/tb_tap_ir_controller.sv
// Scenario tasks with constant expectations, then a random TMS/TDI/TRST walk checked
// against a table-driven model of the TAP and an arithmetic model of the IR.
module tb_tap_ir_controller;

  logic       TCK = 1'b0;
  logic       TRST, TMS, TDI;
  logic [3:0] LATCH_IR, TAP_STATE;
  logic       IR_TDO, TDO_ENABLE, TAP_RESET, SELECT_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR;

  int errors = 0;
  int checks = 0;

  // Reference model
  logic [3:0] nxt0 [16];
  logic [3:0] nxt1 [16];
  logic [3:0] m_st, m_sr, m_latch;
  localparam logic [15:0] IR_STATE_MASK = 16'h6F10;

  tap_ir_controller dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI),
    .LATCH_IR(LATCH_IR), .IR_TDO(IR_TDO), .TDO_ENABLE(TDO_ENABLE),
    .TAP_STATE(TAP_STATE), .TAP_RESET(TAP_RESET), .SELECT_IR(SELECT_IR),
    .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR)
  );

  always #5 TCK = ~TCK;

  task automatic set_edge(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
    nxt0[s] = n0;
    nxt1[s] = n1;
  endtask

  task automatic init_table();
    set_edge(4'hF, 4'hC, 4'hF); set_edge(4'hC, 4'hC, 4'h7);
    set_edge(4'h7, 4'h6, 4'h4); set_edge(4'h4, 4'hE, 4'hF);
    set_edge(4'h6, 4'h2, 4'h1); set_edge(4'h2, 4'h2, 4'h1);
    set_edge(4'h1, 4'h3, 4'h5); set_edge(4'h3, 4'h3, 4'h0);
    set_edge(4'h0, 4'h2, 4'h5); set_edge(4'h5, 4'hC, 4'h7);
    set_edge(4'hE, 4'hA, 4'h9); set_edge(4'hA, 4'hA, 4'h9);
    set_edge(4'h9, 4'hB, 4'hD); set_edge(4'hB, 4'hB, 4'h8);
    set_edge(4'h8, 4'hA, 4'hD); set_edge(4'hD, 4'hC, 4'h7);
  endtask

  // One TCK rise with the given TMS/TDI; returns 1 ns after the edge.
  task automatic tick(input logic t, input logic d);
    logic [3:0] sr_old;
    TMS = t;
    TDI = d;
    @(posedge TCK);
    sr_old = m_sr;
    if (m_st == 4'hE) m_sr = 4'h1;
    else if (m_st == 4'hA) m_sr = (m_sr >> 1) | ({3'b000, d} << 3);
    if (m_st == 4'hD) m_latch = sr_old;
    else if (m_st == 4'hF) m_latch = 4'h7;
    m_st = t ? nxt1[m_st] : nxt0[m_st];
    #1;
  endtask

  // Asynchronous TRST pulse placed between clock edges.
  task automatic pulse_trst();
    #2 TRST = 1'b1;
    m_st = 4'hF; m_sr = 4'h1; m_latch = 4'h7;
    #2 TRST = 1'b0;
  endtask

  task automatic test_reset();
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0;
    #3;
    checks++; if (TAP_STATE !== 4'hF) begin errors++; $display("FAIL reset_state got=%h exp=f", TAP_STATE); end
    checks++; if (LATCH_IR !== 4'h7) begin errors++; $display("FAIL reset_latch got=%h exp=7", LATCH_IR); end
    checks++; if ({TAP_RESET, SELECT_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDO_ENABLE} !== 6'b100000) begin
      errors++; $display("FAIL reset_strobes got=%b exp=100000",
                         {TAP_RESET, SELECT_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDO_ENABLE});
    end
    checks++; if (IR_TDO !== 1'b1) begin errors++; $display("FAIL reset_ir_tdo got=%b exp=1", IR_TDO); end
    @(negedge TCK);
    TRST = 1'b0;
    m_st = 4'hF; m_sr = 4'h1; m_latch = 4'h7;
    tick(1'b1, 1'b0);
    checks++; if (TAP_STATE !== 4'hF) begin errors++; $display("FAIL tlr_hold got=%h exp=f", TAP_STATE); end
  endtask

  task automatic test_ir_scan();
    logic [3:0] seen;
    logic [3:0] tdi_bits;
    tdi_bits = 4'b0010;
    tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    checks++; if (TAP_STATE !== 4'hA) begin errors++; $display("FAIL ir_scan_sh got=%h exp=a", TAP_STATE); end
    checks++; if ({SELECT_IR, TDO_ENABLE} !== 2'b11) begin errors++; $display("FAIL ir_scan_sel got=%b exp=11", {SELECT_IR, TDO_ENABLE}); end
    for (int i = 0; i < 4; i++) begin
      seen[i] = IR_TDO;
      tick(i == 3, tdi_bits[i]);
    end
    checks++; if (seen !== 4'b0001) begin errors++; $display("FAIL ir_tdo_stream got=%b exp=0001 (lsb first)", seen); end
    checks++; if (TAP_STATE !== 4'h9) begin errors++; $display("FAIL ir_scan_ex1 got=%h exp=9", TAP_STATE); end
    tick(1'b1, 1'b0);
    checks++; if (TAP_STATE !== 4'hD || LATCH_IR !== 4'h7) begin
      errors++; $display("FAIL ir_scan_upd state=%h latch=%h exp d/7", TAP_STATE, LATCH_IR);
    end
    tick(1'b0, 1'b0);
    checks++; if (LATCH_IR !== 4'h2) begin errors++; $display("FAIL ir_scan_latch got=%h exp=2", LATCH_IR); end
  endtask

  task automatic test_tms_reset();
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    checks++; if (TAP_STATE !== 4'h2 || SHIFT_DR !== 1'b1) begin
      errors++; $display("FAIL tms_reset_shdr state=%h shift_dr=%b exp 2/1", TAP_STATE, SHIFT_DR);
    end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    checks++; if (TAP_STATE !== 4'hF || TAP_RESET !== 1'b1) begin
      errors++; $display("FAIL tms_reset_tlr state=%h tap_reset=%b exp f/1", TAP_STATE, TAP_RESET);
    end
    checks++; if (LATCH_IR !== 4'h2) begin errors++; $display("FAIL tms_reset_latch_pre got=%h exp=2", LATCH_IR); end
    tick(1'b1, 1'b0);
    checks++; if (LATCH_IR !== 4'h7) begin errors++; $display("FAIL tms_reset_latch got=%h exp=7", LATCH_IR); end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_ir_pause();
    logic [3:0] val;
    int bad;
    val = 4'h3;
    bad = 0;
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, val[i]);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (TAP_STATE !== 4'hB || LATCH_IR !== 4'h7) bad++;
      if (i < 9) tick(1'b0, 1'b0);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pause_hold bad_cycles=%0d exp=0 (state=%h latch=%h)", bad, TAP_STATE, LATCH_IR); end
    tick(1'b1, 1'b0);
    checks++; if (TAP_STATE !== 4'h8 || LATCH_IR !== 4'h7) begin
      errors++; $display("FAIL pause_ex2 state=%h latch=%h exp 8/7", TAP_STATE, LATCH_IR);
    end
    tick(1'b1, 1'b0);
    checks++; if (TAP_STATE !== 4'hD || LATCH_IR !== 4'h7) begin
      errors++; $display("FAIL pause_upd state=%h latch=%h exp d/7", TAP_STATE, LATCH_IR);
    end
    tick(1'b0, 1'b0);
    checks++; if (LATCH_IR !== 4'h3) begin errors++; $display("FAIL pause_latch got=%h exp=3", LATCH_IR); end
  endtask

  task automatic test_dr_scan();
    logic [3:0] tms_seq [8];
    logic [3:0] exp_st  [8];
    logic [2:0] exp_str [8];
    tms_seq = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
    exp_st  = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h2, 4'h1, 4'h5, 4'hC};
    exp_str = '{3'b000, 3'b100, 3'b010, 3'b010, 3'b010, 3'b000, 3'b001, 3'b000};
    for (int i = 0; i < 8; i++) begin
      tick(tms_seq[i][0], 1'b1);
      checks++;
      if (TAP_STATE !== exp_st[i] || {CAPTURE_DR, SHIFT_DR, UPDATE_DR} !== exp_str[i] || SELECT_IR !== 1'b0) begin
        errors++;
        $display("FAIL dr_scan_step%0d state=%h cap/sh/upd=%b sel_ir=%b exp %h/%b/0",
                 i, TAP_STATE, {CAPTURE_DR, SHIFT_DR, UPDATE_DR}, SELECT_IR, exp_st[i], exp_str[i]);
      end
    end
    checks++; if (LATCH_IR !== 4'h3) begin errors++; $display("FAIL dr_scan_latch got=%h exp=3", LATCH_IR); end
  endtask

  task automatic test_trst_mid_shift();
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    tick(1'b0, 1'b0); tick(1'b0, 1'b1);
    checks++; if (TAP_STATE !== 4'hA || IR_TDO !== 1'b0) begin
      errors++; $display("FAIL trst_pre state=%h ir_tdo=%b exp a/0", TAP_STATE, IR_TDO);
    end
    #2 TRST = 1'b1;
    m_st = 4'hF; m_sr = 4'h1; m_latch = 4'h7;
    #1;
    checks++; if (TAP_STATE !== 4'hF || LATCH_IR !== 4'h7 || TAP_RESET !== 1'b1) begin
      errors++; $display("FAIL trst_async state=%h latch=%h tap_reset=%b exp f/7/1", TAP_STATE, LATCH_IR, TAP_RESET);
    end
    checks++; if (IR_TDO !== 1'b1 || TDO_ENABLE !== 1'b0) begin
      errors++; $display("FAIL trst_sr ir_tdo=%b tdo_en=%b exp 1/0", IR_TDO, TDO_ENABLE);
    end
    #1 TRST = 1'b0;
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    checks++; if (LATCH_IR !== 4'h7 || TAP_STATE !== 4'hC) begin
      errors++; $display("FAIL trst_after latch=%h state=%h exp 7/c", LATCH_IR, TAP_STATE);
    end
  endtask

  task automatic test_random();
    logic t, d;
    logic [5:0] exp_dec;
    int bad;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) pulse_trst();
      t = ($urandom_range(0, 2) == 0);
      d = $urandom_range(0, 1) == 1;
      tick(t, d);
      exp_dec = {m_st == 4'hF, IR_STATE_MASK[m_st], m_st == 4'h6, m_st == 4'h2,
                 m_st == 4'h5, (m_st == 4'h2) || (m_st == 4'hA)};
      checks++;
      if (TAP_STATE !== m_st || LATCH_IR !== m_latch || IR_TDO !== m_sr[0] ||
          {TAP_RESET, SELECT_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDO_ENABLE} !== exp_dec) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_step%0d state=%h/%h latch=%h/%h tdo=%b/%b dec=%b/%b (got/exp)",
                   i, TAP_STATE, m_st, LATCH_IR, m_latch, IR_TDO, m_sr[0],
                   {TAP_RESET, SELECT_IR, CAPTURE_DR, SHIFT_DR, UPDATE_DR, TDO_ENABLE}, exp_dec);
      end
    end
  endtask

  initial begin
    init_table();
    test_reset();
    test_ir_scan();
    test_tms_reset();
    test_ir_pause();
    test_dr_scan();
    test_trst_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
